// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side drain engine.
// Occupancy encoding, default data width and burst-counter sizing.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam int DW_DEFAULT = 8;

  // A single-word burst still needs a 1-bit counter to stay a legal vector.
  function automatic int bcnt_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/skid output buffer with push, pop and flush.
// Latency: a push lands in head (or skid) at the same edge; vld_o is registered state.
// Backpressure: pop_rdy_i only moves data between registers, never reaches push_i.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output occ_e         occ_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;
  logic         push;

  assign vld_o = (occ_q != EMPTY);
  assign dat_o = head_q;
  assign occ_o = occ_q;
  assign pop   = vld_o && pop_rdy_i;
  assign push  = push_i && (occ_q != FULL);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) begin
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (push) begin
            head_d = push_dat_i;
            occ_d  = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = push_dat_i;
          end else if (push) begin
            skid_d = push_dat_i;
            occ_d  = FULL;
          end else if (pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d = skid_q;
            occ_d  = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a registered valid/ready stream with m_last framing; FIFO_RD_STREAM_CNT_EN adds rd_count.
// Latency: m_valid rises one rclk after rempty falls; full throughput with occupancy held at ONE.
// Backpressure: absorbed by the 2-entry buffer; rinc depends only on rempty, flush, rrst and occupancy.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int BURST_LEN = 4
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]   rd_count
`endif
);

  localparam int            BW       = bcnt_width(BURST_LEN);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BURST_LEN - 1);

  occ_e          occ;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          last_w;
  logic [DW:0]   buf_dat;

  // Pop strobe deliberately ignores m_ready so no ready-to-rinc path exists.
  assign rinc   = !rempty && (occ != FULL) && !flush && !rrst;
  assign last_w = (bcnt_q == BCNT_MAX);

  always_comb begin
    bcnt_d = bcnt_q;
    if (flush) begin
      bcnt_d = '0;
    end else if (rinc) begin
      bcnt_d = last_w ? '0 : bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  fifo_rd_skid #(
    .W(DW + 1)
  ) u_skid (
    .clk_i      (rclk),
    .rst_i      (rrst),
    .flush_i    (flush),
    .push_i     (rinc),
    .push_dat_i ({last_w, rdata}),
    .pop_rdy_i  (m_ready),
    .vld_o      (m_valid),
    .dat_o      (buf_dat),
    .occ_o      (occ)
  );

  assign m_last = buf_dat[DW];
  assign m_data = buf_dat[DW-1:0];

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (m_valid && m_ready) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed table, hand sequences and a random run against a queue-based model.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rrst, rempty, rinc, flush, m_valid, m_ready, m_last;
  logic [DW-1:0] rdata, m_data;
  logic          rempty1, rinc1, m_valid1, m_ready1, m_last1;
  logic [DW-1:0] rdata1, m_data1;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]   rd_count, rd_count1;
`endif

  fifo_rd_stream #(.DW(DW), .BURST_LEN(BL)) u0 (
    .rclk    (clk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  fifo_rd_stream #(.DW(DW), .BURST_LEN(1)) u1 (
    .rclk    (clk),
    .rrst    (rrst),
    .rempty  (rempty1),
    .rdata   (rdata1),
    .rinc    (rinc1),
    .flush   (flush),
    .m_valid (m_valid1),
    .m_ready (m_ready1),
    .m_data  (m_data1),
    .m_last  (m_last1)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .rd_count(rd_count1)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   pend[$];
  logic [DW:0]   dlv[$];
  int            idx, cnt, rinc_pulses;
  logic          hold_empty, sb_on;

  typedef struct packed {
    logic          rdy;
    logic          e_rinc;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic          e_last;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    rempty  = hold_empty || (fifo_q.size() == 0);
    rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    rempty1 = (q1.size() == 0);
    rdata1  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // One rclk: check against the model just before the edge, advance model, refresh FIFO after the edge.
  task automatic tick();
    logic m_rinc, acc, p1;
    #1;
    m_rinc = !rempty && (pend.size() < 2) && !flush && !rrst;
    acc    = (pend.size() != 0) && m_ready;
    if (sb_on) begin
      chk("rinc", {31'd0, rinc}, {31'd0, m_rinc});
      chk("m_valid", {31'd0, m_valid}, {31'd0, pend.size() != 0});
      if (pend.size() != 0) chk("head", {23'd0, m_last, m_data}, {23'd0, pend[0]});
    end
    if (rinc) rinc_pulses++;
    p1 = rinc1;
    if (rrst || flush) begin
      pend.delete();
      idx = 0;
      cnt = 0;
    end else begin
      if (acc) begin
        dlv.push_back(pend.pop_front());
        cnt++;
      end
      if (m_rinc) begin
        pend.push_back({idx == BL - 1, rdata});
        idx = (idx + 1) % BL;
      end
    end
    @(posedge clk);
    #1;
    if (m_rinc) void'(fifo_q.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    drive_fifo();
`ifdef FIFO_RD_STREAM_CNT_EN
    if (sb_on) chk("rd_count", rd_count, cnt);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || pend.size() != 0); i++) tick();
    chk("drain_left", fifo_q.size() + pend.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] w[16];
    logic [DW-1:0] wd;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    sb_on = 1'b0; rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; m_ready1 = 1'b1;
    hold_empty = 1'b0; idx = 0; cnt = 0; rinc_pulses = 0;
    drive_fifo();
    tick();
    sb_on = 1'b1;
    tick();
    rrst = 1'b0;
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_valid1", {31'd0, m_valid1}, 0);

    // Preloaded 5 words, steady streaming
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_fifo();
    for (int i = 0; i < 6; i++) begin
      m_ready = tbl[i].rdy;
      #1;
      chk("t1_rinc", {31'd0, rinc}, {31'd0, tbl[i].e_rinc});
      tick();
      chk("t1_valid", {31'd0, m_valid}, {31'd0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        chk("t1_data", {24'd0, m_data}, {24'd0, tbl[i].e_dat});
        chk("t1_last", {31'd0, m_last}, {31'd0, tbl[i].e_last});
      end
    end

    // Backpressure for 10 cycles with 6 words waiting
    dlv.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wd = 8'hA0 + 8'(i);
      fifo_q.push_back(wd);
    end
    drive_fifo();
    rinc_pulses = 0;
    repeat (10) tick();
    chk("bp_pulses", rinc_pulses, 2);
    chk("bp_valid", {31'd0, m_valid}, 1);
    chk("bp_data", {24'd0, m_data}, 32'hA0);
    m_ready = 1'b1;
    drain();
    chk("bp_count", dlv.size(), 6);
    for (int i = 0; i < 6 && i < dlv.size(); i++) chk("bp_order", {24'd0, dlv[i][DW-1:0]}, 32'hA0 + i);

    // 16 random words with ready toggling
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    dlv.delete();
    for (int i = 0; i < 16; i++) begin
      w[i] = 8'($urandom);
      fifo_q.push_back(w[i]);
    end
    drive_fifo();
    for (int i = 0; i < 80 && (fifo_q.size() != 0 || pend.size() != 0); i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    drain();
    chk("tog_count", dlv.size(), 16);
    for (int i = 0; i < 16 && i < dlv.size(); i++) begin
      chk("tog_data", {24'd0, dlv[i][DW-1:0]}, {24'd0, w[i]});
      chk("tog_last", {31'd0, dlv[i][DW]}, {31'd0, (i % 4) == 3});
    end

    // Flush with buffer full and bcnt=2
    dlv.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      fifo_q.push_back(w[i]);
    end
    drive_fifo();
    repeat (3) tick();
    chk("fl_full_valid", {31'd0, m_valid}, 1);
    chk("fl_full_rinc", {31'd0, rinc}, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, m_valid}, 0);
    for (int i = 3; i < 7; i++) begin
      w[i] = 8'($urandom);
      fifo_q.push_back(w[i]);
    end
    drive_fifo();
    m_ready = 1'b1;
    drain();
    chk("fl_count", dlv.size(), 5);
    for (int i = 0; i < 5 && i < dlv.size(); i++) begin
      chk("fl_data", {24'd0, dlv[i][DW-1:0]}, {24'd0, w[i + 2]});
      chk("fl_last", {31'd0, dlv[i][DW]}, {31'd0, i == 3});
    end

    // Reset mid-burst with 2 words buffered
    dlv.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'($urandom);
      fifo_q.push_back(w[i]);
    end
    drive_fifo();
    repeat (3) tick();
    rrst = 1'b1;
    #1;
    chk("rr_rinc", {31'd0, rinc}, 0);
    tick();
    chk("rr_valid", {31'd0, m_valid}, 0);
    chk("rr_data", {24'd0, m_data}, 0);
    chk("rr_last", {31'd0, m_last}, 0);
    chk("rr_rinc_hold", {31'd0, rinc}, 0);
    tick();
    rrst = 1'b0;
    m_ready = 1'b1;
    drain();
    chk("rr_count", dlv.size(), 4);
    for (int i = 0; i < 4 && i < dlv.size(); i++) begin
      chk("rr_data", {24'd0, dlv[i][DW-1:0]}, {24'd0, w[i + 2]});
      chk("rr_last", {31'd0, dlv[i][DW]}, {31'd0, i == 3});
    end

    // Random traffic, flushes and resets against the model
    for (int i = 0; i < 400; i++) begin
      m_ready    = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      rrst       = ($urandom_range(0, 59) == 0);
      hold_empty = ($urandom_range(0, 4) == 0);
      if (fifo_q.size() < 5 && $urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
      drive_fifo();
      tick();
    end
    flush = 1'b0; rrst = 1'b0; hold_empty = 1'b0; m_ready = 1'b1;
    drive_fifo();
    drain();

    // BURST_LEN=1 instance: every word is last
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      q1.push_back(w[i]);
    end
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b1_valid", {31'd0, m_valid1}, 1);
      chk("b1_data", {24'd0, m_data1}, {24'd0, w[i]});
      chk("b1_last", {31'd0, m_last1}, 1);
    end
    tick();
    chk("b1_idle", {31'd0, m_valid1}, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("b1_count", rd_count1, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
